wbpwm_capture: RTL and testbench
================================

# wbpwm_capture

Wishbone-slave PWM/PDM audio capture block: the receive end of the one-bit PWM audio link that the PWM audio output block drives. It synchronizes a one-bit PWM input and counts high cycles over fixed windows of 2^NBITS clocks, converting each window's duty cycle back into a signed PCM sample. Samples are buffered in a small FIFO that the CPU drains over Wishbone, and an interrupt signals pending data. It is used for loopback verification of the audio output path and for capturing external PDM sources.

## Interface
- NBITS, 16: sample width; capture window is 2^NBITS clocks.
- LGFIFO, 3: log2 FIFO depth (8 entries).
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous reset, active-high.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  1  register select: 0 = DATA, 1 = CTRL.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte selects; writes act only when i_wb_sel[0] is set.
- o_wb_stall  out  1  tied 0.
- o_wb_ack  out  1  bus acknowledge.
- o_wb_data  out  32  read data.
- i_pwm  in  1  asynchronous PWM/PDM input.
- o_int  out  1  level interrupt: FIFO non-empty AND CTRL.ie.

## Operation
- Input path: i_pwm passes through a 2-FF synchronizer before the counter.
- Window: when CTRL.en = 1, the window counter runs 0..2^NBITS-1. The ones-accumulator (NBITS+1 bits) adds the synchronized bit each cycle.
- At the window's last cycle, the final count c (including that cycle) is saturated to 2^NBITS-1. Sample s = sat(c) - 2^(NBITS-1), NBITS-bit two's complement. The accumulator restarts at 0.
- Sample s is pushed to the FIFO on the cycle after the window ends.
- FIFO full on push: the sample is dropped and the sticky CTRL.ovf is set.
- Push and pop in the same cycle while full: both occur, and ovf is not set.
- DATA read (addr 0):
  - Non-empty: returns {1'b1, zeros, s sign-extended to 31 bits} and pops one entry.
  - Empty: returns 0 and does not pop.
- DATA writes are ignored.
- CTRL (addr 1) read: bit0 en, bit1 ie, bit2 ovf, bit3 full, bits[8+LGFIFO:8] fill level, all other bits 0.
- CTRL write:
  - bit0 sets en; bit1 sets ie.
  - Writing 1 to bit2 clears ovf (write-1-to-clear).
  - Writing 1 to bit4 flushes the FIFO. This is self-clearing and reads as 0.
- Clearing en clears the window counter and accumulator and holds them at 0. FIFO contents are retained.
- Setting en starts a fresh window on the next cycle.

## Timing
- Reset values: o_wb_ack=0, o_wb_data=0, o_int=0, en=0, ie=0, ovf=0, FIFO empty, counters 0, synchronizer 0.
- Wishbone is pipelined with no stall. o_wb_ack is asserted exactly one cycle after i_wb_stb && i_wb_cyc. o_wb_data is valid in the same cycle as the ack.
- If i_wb_cyc drops, the pending ack is still issued. The DATA pop and CTRL side effects happen on the strobe cycle regardless.
- Latency from i_pwm to counting: 2 cycles.
- A sample is visible in the fill level, and o_int updates, 1 cycle after its window ends.
- Reset mid-window discards the partial window. Reset mid-bus-cycle suppresses the pending ack.
- Fill level range: 0..2^LGFIFO. Pointers are LGFIFO+1 bits and wrap modulo 2^(LGFIFO+1).

## Structure
- Shared package holds the register address constants (ADDR_DATA=0, ADDR_CTRL=1) and the CTRL bit positions (EN=0, IE=1, OVF=2, FULL=3, FLUSH=4, FILL_LSB=8).
- One sub-module: sfifo, a synchronous FIFO with parameters BW=NBITS and LGFLEN=LGFIFO. Its ports are write, read, data, full, empty and fill, plus a synchronous flush input.
- The top level contains the synchronizer, the window counter/accumulator and the Wishbone register logic.

## Test plan
All scenarios use NBITS=4 (16-clock window) and LGFIFO=2.
- i_pwm held at 1, en=1, after one window -> DATA read = 0x80000007. o_int=1 when ie=1.
- i_pwm held at 0 -> DATA read = 0xFFFFFFF8 with bit31 set, i.e. 0xFFFFFFF8 | 0x80000000 = 0xFFFFFFF8. Then read again with the FIFO empty -> 0x00000000.
- i_pwm toggling every clock (50% duty) -> sample 0; DATA read = 0x80000000.
- Let 6 windows elapse without reads -> CTRL read shows full=1, fill=4, ovf=1. Write CTRL bit2=1 -> ovf=0. Write bit4=1 -> fill=0 and o_int=0.
- Clear en mid-window with 5 highs counted, then re-enable and run a full all-low window -> sample = -8 (partial count discarded).
- Assert i_reset during an active window with the FIFO non-empty -> the next cycle shows all outputs at 0, the FIFO empty and en=0.

Source files
------------

// File: rtl/wbpwm_capture_pkg.sv
// Shared register map for the PWM/PDM capture block: bus addresses and CTRL bit positions.
package wbpwm_capture_pkg;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_IE       = 1;
    localparam int unsigned CTRL_OVF      = 2;
    localparam int unsigned CTRL_FULL     = 3;
    localparam int unsigned CTRL_FLUSH    = 4;
    localparam int unsigned CTRL_FILL_LSB = 8;

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO with first-word-fall-through read data and a synchronous flush.
module sfifo #(
    parameter int unsigned BW     = 16,
    parameter int unsigned LGFLEN = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty
);
    localparam int unsigned DEPTH = 1 << LGFLEN;

    logic [BW-1:0]   r_mem [DEPTH];
    logic [LGFLEN:0] r_wptr, r_rptr;
    logic            w_wr, w_rd;

    assign o_fill  = r_wptr - r_rptr;
    assign o_full  = o_fill[LGFLEN];
    assign o_empty = (o_fill == '0);
    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    assign w_wr    = i_wr && (!o_full || i_rd);
    assign w_rd    = i_rd && !o_empty;
    assign o_data  = r_mem[r_rptr[LGFLEN-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[LGFLEN-1:0]] <= i_data;
    end

endmodule

// File: rtl/wbpwm_capture.sv
// Wishbone-slave PWM/PDM capture: counts high cycles per 2^NBITS-clock window and queues
// the resulting signed samples for the CPU.
module wbpwm_capture
    import wbpwm_capture_pkg::*;
#(
    parameter int unsigned NBITS  = 16,
    parameter int unsigned LGFIFO = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_pwm,
    output logic        o_int
);
    logic [1:0]       r_sync;
    logic [NBITS-1:0] r_wcnt;
    logic [NBITS:0]   r_acc;
    logic             r_en, r_ie, r_ovf, r_ack;
    logic [31:0]      r_rdata;

    logic             w_stb, w_wr_ctrl, w_pop, w_flush, w_last;
    logic [NBITS:0]   w_count;
    logic [NBITS-1:0] w_sat, w_sample, w_fifo_data;
    logic             w_full, w_empty;
    logic [LGFIFO:0]  w_fill;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_stb     = i_wb_cyc && i_wb_stb;
    assign w_wr_ctrl = w_stb && i_wb_we && (i_wb_addr == ADDR_CTRL) && i_wb_sel[0];
    assign w_pop     = w_stb && !i_wb_we && (i_wb_addr == ADDR_DATA) && !w_empty;
    assign w_flush   = w_wr_ctrl && i_wb_data[CTRL_FLUSH];
    assign w_unused  = ^{i_wb_sel[3:1], i_wb_data[31:5], i_wb_data[3]};

    // Count includes the current cycle; a full window of ones saturates to the top code.
    assign w_last   = r_en && (r_wcnt == '1);
    assign w_count  = r_acc + {{NBITS{1'b0}}, r_sync[1]};
    assign w_sat    = w_count[NBITS] ? '1 : w_count[NBITS-1:0];
    assign w_sample = {~w_sat[NBITS-1], w_sat[NBITS-2:0]};

    sfifo #(
        .BW     (NBITS),
        .LGFLEN (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_wr    (w_last),
        .i_data  (w_sample),
        .o_full  (w_full),
        .o_fill  (w_fill),
        .i_rd    (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_wcnt <= '0;
            r_acc  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pwm};
            if (!r_en) begin
                r_wcnt <= '0;
                r_acc  <= '0;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
                r_acc  <= w_last ? '0 : w_count;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (i_wb_addr == ADDR_DATA) begin
            if (!w_empty) begin
                w_rdata = {1'b1, {(31-NBITS){w_fifo_data[NBITS-1]}}, w_fifo_data};
            end
        end else begin
            w_rdata[CTRL_EN]   = r_en;
            w_rdata[CTRL_IE]   = r_ie;
            w_rdata[CTRL_OVF]  = r_ovf;
            w_rdata[CTRL_FULL] = w_full;
            w_rdata[CTRL_FILL_LSB +: LGFIFO+1] = w_fill;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_ovf   <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_stb;
            r_rdata <= w_stb ? w_rdata : '0;
            if (w_wr_ctrl) begin
                r_en <= i_wb_data[CTRL_EN];
                r_ie <= i_wb_data[CTRL_IE];
                if (i_wb_data[CTRL_OVF]) r_ovf <= 1'b0;
            end
            // Dropped sample wins over a same-cycle clear so an overflow is never missed.
            if (w_last && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_int      = r_ie && !w_empty;

endmodule

// File: tb/tb_wbpwm_capture.sv
// Directed and randomized bench for wbpwm_capture with NBITS=4, LGFIFO=2.
module tb_wbpwm_capture;
    localparam int unsigned NB = 4;
    localparam int unsigned LG = 2;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0, i_wb_addr = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        o_wb_stall, o_wb_ack, o_int;
    logic [31:0] o_wb_data;
    logic        i_pwm = 1'b0;

    logic [15:0] pat = '0;
    int          g = 0;
    int          n_checks = 0, n_pass = 0;
    logic [31:0] rd;
    logic [15:0] rp;

    always #5 clk = ~clk;

    wbpwm_capture #(.NBITS(NB), .LGFIFO(LG)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .i_pwm      (i_pwm),
        .o_int      (o_int)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // The input is a 16-cycle periodic pattern, so any window sees exactly popcount(pat) ones.
    task automatic tick();
        @(posedge clk);
        #1;
        g++;
        i_pwm = pat[g % 16];
    endtask

    function automatic logic [31:0] exp_sample(input logic [15:0] p);
        int pc = 0;
        int s;
        for (int i = 0; i < 16; i++) pc += int'(p[i]);
        if (pc > 15) pc = 15;
        s = pc - 8;
        return 32'h8000_0000 | (32'(s) & 32'h7FFF_FFFF);
    endfunction

    task automatic wb(input logic we, input logic addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr;
        i_wb_data = wdata; i_wb_sel = 4'hF;
        tick();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        check("ack", {31'd0, o_wb_ack}, 32'd1);
        rdata = o_wb_data;
        tick();
    endtask

    task automatic run(input logic [15:0] p, input int nwin);
        logic [31:0] dummy;
        pat = p;
        repeat (3) tick();
        wb(1'b1, 1'b1, 32'h13, dummy);
        repeat (16 * nwin) tick();
        wb(1'b1, 1'b1, 32'h02, dummy);
    endtask

    initial begin
        repeat (3) tick();
        i_reset = 1'b0;
        check("reset_ack", {31'd0, o_wb_ack}, 32'd0);
        check("reset_data", o_wb_data, 32'd0);
        check("reset_int", {31'd0, o_int}, 32'd0);
        check("reset_stall", {31'd0, o_wb_stall}, 32'd0);
        wb(1'b0, 1'b1, 32'd0, rd);
        check("reset_ctrl", rd, 32'd0);

        // All ones saturates to +7
        run(16'hFFFF, 1);
        check("ones_int", {31'd0, o_int}, 32'd1);
        wb(1'b0, 1'b0, 32'd0, rd);
        check("ones_data", rd, exp_sample(16'hFFFF));
        check("ones_int_after", {31'd0, o_int}, 32'd0);

        // All zeros gives -8, then empty read returns 0
        run(16'h0000, 1);
        wb(1'b0, 1'b0, 32'd0, rd);
        check("zeros_data", rd, exp_sample(16'h0000));
        wb(1'b0, 1'b0, 32'd0, rd);
        check("empty_data", rd, 32'd0);

        // 50% duty
        run(16'hAAAA, 1);
        wb(1'b0, 1'b0, 32'd0, rd);
        check("half_data", rd, exp_sample(16'hAAAA));

        // Overflow: six windows into a four-deep FIFO
        run(16'hFFFF, 6);
        check("ovf_int", {31'd0, o_int}, 32'd1);
        wb(1'b0, 1'b1, 32'd0, rd);
        check("ovf_ctrl", rd, 32'h0000_040E);
        wb(1'b1, 1'b1, 32'h06, rd);
        wb(1'b0, 1'b1, 32'd0, rd);
        check("ovf_clear", rd, 32'h0000_040A);
        wb(1'b1, 1'b1, 32'h12, rd);
        wb(1'b0, 1'b1, 32'd0, rd);
        check("flush_ctrl", rd, 32'h0000_0002);
        check("flush_int", {31'd0, o_int}, 32'd0);

        // Disable mid-window discards the partial count
        pat = 16'hFFFF;
        repeat (3) tick();
        wb(1'b1, 1'b1, 32'h11, rd);
        repeat (3) tick();
        wb(1'b1, 1'b1, 32'h00, rd);
        wb(1'b0, 1'b1, 32'd0, rd);
        check("partial_ctrl", rd, 32'd0);
        pat = 16'h0000;
        repeat (3) tick();
        wb(1'b1, 1'b1, 32'h01, rd);
        repeat (16) tick();
        wb(1'b1, 1'b1, 32'h00, rd);
        wb(1'b0, 1'b0, 32'd0, rd);
        check("partial_data", rd, exp_sample(16'h0000));
        wb(1'b0, 1'b1, 32'd0, rd);
        check("partial_empty", rd, 32'd0);

        // Reset mid-window with data queued and a bus strobe pending
        pat = 16'hFFFF;
        repeat (3) tick();
        wb(1'b1, 1'b1, 32'h13, rd);
        repeat (20) tick();
        check("pre_reset_int", {31'd0, o_int}, 32'd1);
        i_reset = 1'b1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 1'b0;
        tick();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        check("rst_int", {31'd0, o_int}, 32'd0);
        i_reset = 1'b0;
        wb(1'b0, 1'b1, 32'd0, rd);
        check("rst_ctrl", rd, 32'd0);

        // Random periodic patterns, two windows each
        for (int k = 0; k < 5; k++) begin
            rp = 16'($urandom);
            if (k == 0) rp = 16'hFFFE;
            run(rp, 2);
            wb(1'b0, 1'b1, 32'd0, rd);
            check("rnd_ctrl", rd, 32'h0000_0202);
            wb(1'b0, 1'b0, 32'd0, rd);
            check("rnd_data0", rd, exp_sample(rp));
            wb(1'b0, 1'b0, 32'd0, rd);
            check("rnd_data1", rd, exp_sample(rp));
            wb(1'b0, 1'b0, 32'd0, rd);
            check("rnd_empty", rd, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
